// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-tick scheduler.
// Supplies fallback values for the SOURCE_CLK / Output_frequency build macros.
`ifndef SOURCE_CLK
`define SOURCE_CLK 50000000
`endif
`ifndef Output_frequency
`define Output_frequency 115200
`endif

package uart_pkg;

    localparam int unsigned OVS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } sched_state_e;

    // Source clocks per oversample tick for a given baud rate.
    function automatic int unsigned default_div(input int unsigned src_clk,
                                                input int unsigned baud,
                                                input int unsigned ovs);
        return src_clk / (baud * ovs);
    endfunction

endpackage

// File: rtl/baud_div_ctr.sv
// Loadable modulo-N counter with synchronous clear; wrap is high on the
// last count of each period while enabled.
module baud_div_ctr #(
    parameter int unsigned CW = 32
) (
    input  logic          src_clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] div,
    output logic          wrap
);

    logic [CW-1:0] cnt_reg;
    logic          at_top;

    // >= rather than == so a divisor shrinking mid-count cannot run away.
    assign at_top = (cnt_reg >= div - CW'(1));
    assign wrap   = en & at_top;

    always_ff @(posedge src_clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= at_top ? '0 : cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/uart_baud_sched.sv
// Baud-tick scheduler: shared divider, TX/RX sub-counters and deferred reconfig.
// UART_BAUD_DEFAULT_LOAD_EN selects a non-zero reset divisor from SRC_CLK/DEFAULT_BAUD.
`ifndef SOURCE_CLK
`define SOURCE_CLK 50000000
`endif
`ifndef Output_frequency
`define Output_frequency 115200
`endif

module uart_baud_sched
    import uart_pkg::*;
#(
    parameter int unsigned SRC_CLK      = `SOURCE_CLK,
    parameter int unsigned DEFAULT_BAUD = `Output_frequency,
    parameter int unsigned OVS          = OVS_DEFAULT,
    parameter int unsigned CW           = 32
) (
    input  logic          src_clk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_div,
    input  logic          cfg_wr,
    output logic          cfg_ack,
    output logic          cfg_err,
    input  logic          tx_en,
    input  logic          rx_en,
    input  logic          rx_start,
    output logic          ovs_tick,
    output logic          tx_tick,
    output logic          rx_sample,
    output logic          busy
);

    localparam int unsigned SW = $clog2(OVS);
    localparam logic [SW-1:0] TX_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] RX_MID  = SW'(OVS / 2 - 1);

`ifdef UART_BAUD_DEFAULT_LOAD_EN
    localparam bit DEFAULT_LOAD = 1'b1;
`else
    localparam bit DEFAULT_LOAD = 1'b0;
`endif
    localparam logic [CW-1:0] ACTIVE_DIV_RST =
        DEFAULT_LOAD ? CW'(default_div(SRC_CLK, DEFAULT_BAUD, OVS)) : '0;

    sched_state_e  state_reg;
    logic [CW-1:0] active_div_reg;
    logic [CW-1:0] shadow_div_reg;
    logic [SW-1:0] tx_sub_reg;
    logic [SW-1:0] rx_sub_reg;
    logic          ovs_tick_reg;
    logic          tx_tick_reg;
    logic          rx_sample_reg;
    logic          cfg_ack_reg;
    logic          cfg_err_reg;
    logic          busy_reg;

    logic          running;
    logic          run;
    logic          cfg_ok;
    logic          cfg_load;
    logic          div_wrap;
    logic          bit_end;
    logic          ctr_clr;

    always_comb begin
        running  = (state_reg != ST_IDLE);
        run      = tx_en | rx_en;
        cfg_ok   = (cfg_div >= CW'(2));
        cfg_load = cfg_wr & cfg_ok;
        bit_end  = div_wrap & (tx_sub_reg == TX_LAST);
        // Counters restart on every entry to RUN and whenever a new divisor lands.
        ctr_clr  = ~running | ~run | ((state_reg == ST_PEND) & bit_end);
    end

    baud_div_ctr #(
        .CW(CW)
    ) u_div (
        .src_clk (src_clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (running),
        .div     (active_div_reg),
        .wrap    (div_wrap)
    );

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            active_div_reg <= ACTIVE_DIV_RST;
            shadow_div_reg <= '0;
            tx_sub_reg     <= '0;
            rx_sub_reg     <= '0;
            ovs_tick_reg   <= 1'b0;
            tx_tick_reg    <= 1'b0;
            rx_sample_reg  <= 1'b0;
            cfg_ack_reg    <= 1'b0;
            cfg_err_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            ovs_tick_reg  <= div_wrap;
            tx_tick_reg   <= bit_end & tx_en;
            rx_sample_reg <= div_wrap & (rx_sub_reg == RX_MID) & rx_en;
            cfg_err_reg   <= cfg_wr & ~cfg_ok;
            cfg_ack_reg   <= 1'b0;

            if (ctr_clr) begin
                tx_sub_reg <= '0;
            end else if (div_wrap) begin
                tx_sub_reg <= tx_sub_reg + SW'(1);
            end

            // A start bit realigns the RX phase even on a divider wrap.
            if (ctr_clr || rx_start) begin
                rx_sub_reg <= '0;
            end else if (div_wrap) begin
                rx_sub_reg <= rx_sub_reg + SW'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cfg_load) begin
                        active_div_reg <= cfg_div;
                        cfg_ack_reg    <= 1'b1;
                    end
                    if (run && active_div_reg >= CW'(2)) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        if (cfg_load) begin
                            active_div_reg <= cfg_div;
                            cfg_ack_reg    <= 1'b1;
                        end
                    end else if (cfg_load) begin
                        shadow_div_reg <= cfg_div;
                        state_reg      <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // A write landing on the apply cycle wins over the older shadow.
                    if (!run || bit_end) begin
                        active_div_reg <= cfg_load ? cfg_div : shadow_div_reg;
                        cfg_ack_reg    <= 1'b1;
                        state_reg      <= run ? ST_RUN : ST_IDLE;
                        busy_reg       <= run;
                    end else if (cfg_load) begin
                        shadow_div_reg <= cfg_div;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ovs_tick  = ovs_tick_reg;
    assign tx_tick   = tx_tick_reg;
    assign rx_sample = rx_sample_reg;
    assign cfg_ack   = cfg_ack_reg;
    assign cfg_err   = cfg_err_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_baud_sched.sv
// Randomised bench for uart_baud_sched; expected strobes come from a cycle-time
// model (tick at base + k*div, bit boundary at base + k*OVS*div).
module tb_uart_baud_sched;

    localparam int OVS = 16;
    localparam int CW  = 32;
    localparam int BIG = 32'h3fff_ffff;

    logic          src_clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cfg_div = '0;
    logic          cfg_wr = 1'b0;
    logic          tx_en = 1'b0;
    logic          rx_en = 1'b0;
    logic          rx_start = 1'b0;
    logic          cfg_ack, cfg_err, ovs_tick, tx_tick, rx_sample, busy;

    uart_baud_sched #(
        .SRC_CLK      (50000000),
        .DEFAULT_BAUD (115200),
        .OVS          (OVS),
        .CW           (CW)
    ) dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_wr    (cfg_wr),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .rx_start  (rx_start),
        .ovs_tick  (ovs_tick),
        .tx_tick   (tx_tick),
        .rx_sample (rx_sample),
        .busy      (busy)
    );

    always #5 src_clk = ~src_clk;

    int cyc = 0;
    always @(posedge src_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Model: busy over [m_beg, m_end); ticks phase-locked to m_base with period m_div.
    int m_beg = BIG, m_end = BIG, m_base = 0, m_div = 0, m_shadow = 0;
    int m_pend_after = 0, m_ack_at = -1, m_err_at = -1, m_rx_t = BIG;
    bit m_pend = 1'b0;
    bit chk_on = 1'b0;
    bit tx_en_last = 1'b0, rx_en_last = 1'b0;
    int rx_q[$];

    int c_now;
    bit live, bnd, e_ovs, e_tx, e_ack, e_busy;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    always @(negedge src_clk) begin
        if (chk_on) begin
            c_now = cyc;
            live  = (c_now - 1 >= m_beg) && (c_now - 1 < m_end);
            e_ovs = live && (m_div >= 2) && (c_now > m_base) && ((c_now - m_base) % m_div == 0);
            bnd   = e_ovs && ((c_now - m_base) % (OVS * m_div) == 0);
            e_tx  = bnd && tx_en_last;
            e_ack = (c_now == m_ack_at);
            if (m_pend && live && c_now >= m_pend_after && (bnd || c_now == m_end)) begin
                e_ack    = 1'b1;
                m_pend   = 1'b0;
                m_div    = m_shadow;
                m_base   = c_now;
            end
            e_busy = (c_now >= m_beg) && (c_now < m_end);
            check("ovs_tick", ovs_tick, e_ovs);
            check("tx_tick", tx_tick, e_tx);
            check("busy", busy, e_busy);
            check("cfg_ack", cfg_ack, e_ack);
            check("cfg_err", cfg_err, c_now == m_err_at);
            if (rx_sample === 1'b1 && c_now > m_rx_t + 1) rx_q.push_back(c_now);
            if (rx_sample === 1'b1) check("rx_on_ovs", ovs_tick, 1);
            if (!(live && rx_en_last)) check("rx_quiet", rx_sample, 0);
        end
        tx_en_last = tx_en;
        rx_en_last = rx_en;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge src_clk);
            #1;
        end
    endtask

    task automatic set_en(input bit t, input bit r);
        int e = cyc;
        bit was_on = tx_en | rx_en;
        bit idle = !(e >= m_beg && e < m_end);
        tx_en = t;
        rx_en = r;
        if (!(t | r)) begin
            if (!idle) m_end = e + 1;
        end else if (!was_on && idle && m_div >= 2) begin
            m_beg  = e + 1;
            m_base = e + 1;
            m_end  = BIG;
        end
        $display("enable tx=%0d rx=%0d at cycle %0d", t, r, e);
    endtask

    task automatic do_write(input int v);
        int w = cyc;
        bit idle = !(w >= m_beg && w < m_end);
        cfg_div = CW'(v);
        cfg_wr  = 1'b1;
        if (v < 2) begin
            m_err_at = w + 1;
        end else if (idle) begin
            m_div    = v;
            m_ack_at = w + 1;
            if (tx_en | rx_en) begin
                m_beg  = w + 2;
                m_base = w + 2;
                m_end  = BIG;
            end
        end else begin
            if (!m_pend) m_pend_after = w + 2;
            m_pend   = 1'b1;
            m_shadow = v;
        end
        $display("write cfg_div=%0d at cycle %0d", v, w);
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_rx();
        rx_start = 1'b1;
        m_rx_t   = cyc;
        rx_q.delete();
        $display("rx_start at cycle %0d", cyc);
        step(1);
        rx_start = 1'b0;
    endtask

    task automatic wait_offset(input int off, input int limit);
        int k = 0;
        while (!(cyc > m_base && (cyc - m_base) % (OVS * m_div) == off) && k < limit) begin
            step(1);
            k++;
        end
        if (k >= limit) check("offset_timeout", 1, 0);
    endtask

    task automatic wait_pend_clear(input int limit);
        int k = 0;
        while (m_pend && k < limit) begin
            step(1);
            k++;
        end
        if (m_pend) check("pend_timeout", 1, 0);
    endtask

    task automatic rx_align_check();
        int t = m_rx_t;
        int d = m_div;
        step(OVS * d * 2 + (OVS / 2) * d + 2 * d);
        check("rx_count", int'(rx_q.size() >= 3), 1);
        if (rx_q.size() >= 3) begin
            check("rx_first_window", int'(rx_q[0] >= t + (OVS / 2 - 1) * d &&
                                          rx_q[0] <= t + (OVS / 2 + 1) * d), 1);
            check("rx_period_a", rx_q[1] - rx_q[0], OVS * d);
            check("rx_period_b", rx_q[2] - rx_q[1], OVS * d);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: cycle %0d got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int r;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk_on = 1'b1;

        // No divisor loaded yet: enables alone must not start anything.
        set_en(1'b1, 1'b0);
        step(200);

        do_write(4);
        step(3 * OVS * 4 + 10);

        wait_offset(10, 200);
        do_write(8);
        wait_pend_clear(200);
        step(3 * OVS * 8 + 5);

        do_write(1);
        step(150);

        repeat (4) begin
            step($urandom_range(1, 150));
            do_write($urandom_range(2, 12));
            if ($urandom_range(0, 1) == 1) begin
                step($urandom_range(1, 3));
                do_write($urandom_range(0, 1));
                do_write($urandom_range(2, 12));
            end
            wait_pend_clear(400);
            step($urandom_range(20, 100));
        end

        // RX alignment with TX disabled, then a second realignment.
        set_en(1'b0, 1'b1);
        step(5);
        pulse_rx();
        rx_align_check();
        step($urandom_range(5, 60));
        pulse_rx();
        rx_align_check();

        // Two writes while pending, then both enables dropped.
        set_en(1'b1, 1'b1);
        wait_offset(3, 400);
        do_write(6);
        step(1);
        do_write(10);
        step(1);
        set_en(1'b0, 1'b0);
        step(5);
        set_en(1'b1, 1'b0);
        step(3 * OVS * 10 + 5);

        repeat (2) begin
            set_en(1'b0, 1'b0);
            step(4);
            do_write($urandom_range(2, 9));
            step(2);
            set_en(1'b1, $urandom_range(0, 1) == 1);
            step(OVS * m_div * 2 + 5);
        end

        // Reset mid-bit with a write pending: no acknowledge may follow.
        wait_offset(3, 400);
        do_write(7);
        step(2);
        chk_on = 1'b0;
        rst = 1'b1;
        r = cyc;
        $display("reset asserted at cycle %0d", r);
        step(1);
        check("rst_ack", cfg_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_ovs", ovs_tick, 0);
        check("rst_tx", tx_tick, 0);
        step(1);
        rst = 1'b0;
        m_beg = BIG; m_end = BIG; m_base = 0; m_div = 0; m_shadow = 0;
        m_pend = 1'b0; m_ack_at = -1; m_err_at = -1; m_rx_t = BIG;
        chk_on = 1'b1;
        step(100);
        v = $urandom_range(2, 6);
        do_write(v);
        step(OVS * v * 2 + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
